// File: rtl/core_types_pkg.sv
// Shared core configuration constants for the front-end predictors.
package core_types_pkg;

  // Return-address-stack geometry: depth, pointer width and stored target width (PC[31:1]).
  localparam int RAS_ENTRIES      = 8;
  localparam int LOG_RAS_ENTRIES  = $clog2(RAS_ENTRIES);
  localparam int RAS_TARGET_WIDTH = 31;

endpackage : core_types_pkg

// File: rtl/ras.sv
// Return address stack: circular array of return targets with a wrapping top-of-stack
// pointer. Calls push, returns pop, and backend mispredict recovery restores the pointer
// to a checkpointed value. Contents are never restored; only the pointer is.
//
// Request semantics: link_RAS_valid, ret_RAS_valid and update_valid are single-cycle
// valid-only strobes with no ready; the stack always accepts them at the next posedge.
// update_valid wins over push/pop. Outputs are combinational from state and always valid.
module ras #(
  parameter int RAS_ENTRIES      = core_types_pkg::RAS_ENTRIES,
  parameter int LOG_RAS_ENTRIES  = core_types_pkg::LOG_RAS_ENTRIES,
  parameter int RAS_TARGET_WIDTH = core_types_pkg::RAS_TARGET_WIDTH
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        link_RAS_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] link_RAS_pc,
  input  logic                        ret_RAS_valid,
  output logic [RAS_TARGET_WIDTH-1:0] ret_RAS_target,
  output logic [LOG_RAS_ENTRIES-1:0]  ret_RAS_index,
  input  logic                        update_valid,
  input  logic [LOG_RAS_ENTRIES-1:0]  update_ras_index
);

  localparam logic [LOG_RAS_ENTRIES-1:0] PTR_ONE = LOG_RAS_ENTRIES'(1);

  logic [RAS_TARGET_WIDTH-1:0] stack_q [RAS_ENTRIES];
  logic [LOG_RAS_ENTRIES-1:0]  ptr_q;
  logic [LOG_RAS_ENTRIES-1:0]  ptr_d;
  logic                        wr_en;
  logic [LOG_RAS_ENTRIES-1:0]  wr_idx;

  // Next pointer and write select; pointer math wraps on native bit-width overflow.
  always_comb begin
    ptr_d  = ptr_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (update_valid) begin
      // Recovery drops any same-cycle push/pop and never writes the array.
      ptr_d = update_ras_index;
    end else if (link_RAS_valid && !ret_RAS_valid) begin
      ptr_d  = ptr_q + PTR_ONE;
      wr_en  = 1'b1;
      wr_idx = ptr_q + PTR_ONE;
    end else if (!link_RAS_valid && ret_RAS_valid) begin
      ptr_d = ptr_q - PTR_ONE;
    end else if (link_RAS_valid && ret_RAS_valid) begin
      // Tail call: the return consumes the top and the call replaces it in place.
      wr_en  = 1'b1;
      wr_idx = ptr_q;
    end
  end

  // Pointer and array registers; reset clears every entry so stale pops read zero.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr_q <= '0;
      for (int i = 0; i < RAS_ENTRIES; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      if (wr_en) begin
        stack_q[wr_idx] <= link_RAS_pc;
      end
    end
  end

  // Top-of-stack view with zero latency; the index doubles as the downstream checkpoint.
  always_comb begin
    ret_RAS_target = stack_q[ptr_q];
    ret_RAS_index  = ptr_q;
  end

endmodule : ras

// File: doc/ras.md
RAS -- requirements
Module: ras

Interface
REQ-001 Parameter RAS_ENTRIES, default 8: stack depth, power of two.
REQ-002 Parameter LOG_RAS_ENTRIES, default 3: pointer width, $clog2(RAS_ENTRIES).
REQ-003 Parameter RAS_TARGET_WIDTH, default 31: stored target width, PC[31:1].
REQ-004 CLK  input  1  sole clock; all state updates on posedge.
REQ-005 nRST  input  1  asynchronous, active-low reset.
REQ-006 link_RAS_valid  input  1  fetch predicts a call; push requested this cycle.
REQ-007 link_RAS_pc  input  RAS_TARGET_WIDTH  return address to push, already shifted right by 1.
REQ-008 ret_RAS_valid  input  1  fetch predicts a return; pop requested this cycle.
REQ-009 ret_RAS_target  output  RAS_TARGET_WIDTH  current top-of-stack entry, combinational from state.
REQ-010 ret_RAS_index  output  LOG_RAS_ENTRIES  current top-of-stack pointer, the checkpoint value carried downstream.
REQ-011 update_valid  input  1  backend mispredict recovery; restore the pointer.
REQ-012 update_ras_index  input  LOG_RAS_ENTRIES  pointer value to restore.

Function
REQ-013 State SHALL be a RAS_ENTRIES x RAS_TARGET_WIDTH register array plus one LOG_RAS_ENTRIES-bit pointer ptr; no FSM beyond these registers.
REQ-014 ret_RAS_target SHALL equal array[ptr], and ret_RAS_index SHALL equal ptr, in the same cycle with zero latency.
REQ-015 Push only (link=1, ret=0): next ptr = ptr+1 mod RAS_ENTRIES; array[ptr+1] <= link_RAS_pc.
REQ-016 Pop only (link=0, ret=1): next ptr = ptr-1 mod RAS_ENTRIES; array unchanged.
REQ-017 Push and pop in the same cycle (tail-call style): the output SHALL show the old top this cycle; ptr SHALL be unchanged; array[ptr] <= link_RAS_pc.
REQ-018 Pointer arithmetic SHALL wrap modulo RAS_ENTRIES with no full or empty detection. A push beyond depth overwrites the oldest entry. A pop beyond empty returns the stale entry.
REQ-019 update_valid SHALL have priority: next ptr = update_ras_index. Any push or pop in that same cycle SHALL be ignored, and no array write SHALL occur.
REQ-020 Recovery SHALL restore the pointer only; array contents SHALL NOT be restored.
REQ-021 With no request active, all state SHALL hold.

Reset
REQ-022 While nRST=0, ptr SHALL be 0 and every array entry SHALL be 0, asynchronously. ret_RAS_target SHALL read 0 and ret_RAS_index SHALL read 0.
REQ-023 Reset asserted mid-operation SHALL discard any in-flight push, pop or update. The first posedge after deassertion SHALL act on the inputs present at that edge.

Structure
REQ-024 RAS_ENTRIES, LOG_RAS_ENTRIES and RAS_TARGET_WIDTH SHALL be sourced from core_types_pkg as parameter defaults. No new typedefs are needed.
REQ-025 The block SHALL be a single flat module with no sub-modules.
REQ-026 Pointer increment and decrement SHALL use native LOG_RAS_ENTRIES-bit overflow, with no explicit compare.

Verification
REQ-027 Reset, then 3 pushes of 0x100, 0x200, 0x300 -> ret_RAS_index=3 and ret_RAS_target=0x300; then 3 pops -> targets seen 0x300, 0x200, 0x100, and final index=0.
REQ-028 9 pushes of 0x10..0x18 from reset -> index wraps to 1 and target=0x18; entry 1 (old 0x10) is overwritten, so 8 pops return 0x18..0x11.
REQ-029 Pop from reset -> index=7 and target=0 (stale); a following push of 0x55 -> index=0 and target=0x55.
REQ-030 Index=2 with top 0x200, then push and pop together with pc 0x777 -> 0x200 shown that cycle, then index=2 and target=0x777.
REQ-031 Index=5, then update_valid with index 2 plus a push of 0x999 in the same cycle -> index=2, target=the prior array[2], and 0x999 written nowhere.
REQ-032 Assert nRST mid-push between clock edges -> outputs go to 0 immediately, and no write is observed after release.
